// File: rtl/not_bist_pkg.sv
// Shared types and constants for the inverter BIST controller.
package not_bist_pkg;

  localparam int ERR_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    WAIT   = 3'd2,
    CHECK  = 3'd3,
    FINISH = 3'd4
  } state_t;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/not_bist_if.sv
// Run-control and result bundle of the inverter BIST controller.
interface not_bist_if #(parameter int WIDTH = 4);
  import not_bist_pkg::*;

  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] fail_vec;

  modport master (output start, input busy, done, pass, err_count, fail_vec);
  modport slave  (input start, output busy, done, pass, err_count, fail_vec);
endinterface

// File: rtl/not_bist_cmp.sv
// Flags a mismatch when any inverter output fails to be the complement of its input.
module not_bist_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] f,
  output logic             mismatch
);

  assign mismatch = |(f ^ ~x);

endmodule

// File: rtl/not_bist_ctrl.sv
// Exhaustive BIST sequencer for a bank of WIDTH inverters.
// Optional first-failure capture on fail_vec is enabled by NOT_BIST_FAIL_CAPTURE_EN.
//
// state  | meaning
// IDLE   | waiting for start, dut_x holds last pattern
// DRIVE  | apply pattern counter to dut_x, load settle timer
// WAIT   | settle timer counts down to terminal count
// CHECK  | compare dut_f with ~dut_x, advance or finish
// FINISH | pulse done, publish pass, drop busy
module not_bist_ctrl
  import not_bist_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] dut_x,
  input  logic [WIDTH-1:0] dut_f,
  not_bist_if.slave        bus
);

  localparam logic [3:0]     SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [WIDTH:0] PAT_LAST  = {1'b0, {WIDTH{1'b1}}};

  state_t           state;
  logic [WIDTH:0]   pat;
  logic [3:0]       settle;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic             mismatch;
  logic             accept;

  // A start seen during the done cycle is dropped so a held start cannot chain runs.
  assign accept = (state == IDLE) && bus.start && !done_q;

  not_bist_cmp #(.WIDTH(WIDTH)) u_cmp (
    .x        (dut_x),
    .f        (dut_f),
    .mismatch (mismatch)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pat    <= '0;
      settle <= '0;
      dut_x  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            pat    <= '0;
            err_q  <= '0;
            pass_q <= 1'b0;
            busy_q <= 1'b1;
            state  <= DRIVE;
          end
        end
        DRIVE: begin
          dut_x  <= pat[WIDTH-1:0];
          settle <= SETTLE_LD;
          state  <= WAIT;
        end
        WAIT: begin
          if (settle == 4'd0) state <= CHECK;
          else                settle <= settle - 4'd1;
        end
        CHECK: begin
          if (mismatch) err_q <= sat_inc(err_q);
          if (pat == PAT_LAST) begin
            state <= FINISH;
          end else begin
            pat   <= pat + 1'b1;
            state <= DRIVE;
          end
        end
        FINISH: begin
          done_q <= 1'b1;
          pass_q <= (err_q == '0);
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;

`ifdef NOT_BIST_FAIL_CAPTURE_EN
  logic [WIDTH-1:0] fail_q;

  // err_q is still zero at the first mismatching CHECK of a run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         fail_q <= '0;
    else if (accept)                                 fail_q <= '0;
    else if (state == CHECK && mismatch && err_q == '0) fail_q <= dut_x;
  end

  assign bus.fail_vec = fail_q;
`else
  assign bus.fail_vec = '0;
`endif

endmodule
